// File: rtl/ram_sp_clear_if.sv
// Request/response bundle for the single-port RAM with zero-fill sweep.
interface ram_sp_clear_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 8
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] in;
  logic                  write;
  logic [NUM_BYTES-1:0]  byte_en;
  logic                  read;
  logic                  clear;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;
  logic                  ready;

  // Requester side
  modport master (
    output address, in, write, byte_en, read, clear,
    input  out, out_valid, ready
  );

  // Memory side
  modport slave (
    input  address, in, write, byte_en, read, clear,
    output out, out_valid, ready
  );

endinterface

// File: rtl/ram_sp_clear.sv
// Single-port synchronous RAM with byte-lane writes, qualified reads,
// optional output register and a hardware zero-fill sweep.
module ram_sp_clear #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic           clock,
  input logic           reset_n,
  ram_sp_clear_if.slave bus
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] w_count_nxt;
  logic                  w_clr_we;
  logic                  w_acc_en;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_wmask;
  logic [DATA_WIDTH-1:0] w_old_word;
  logic [DATA_WIDTH-1:0] w_merged;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // State and sweep counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state logic: sweep ends on the cycle that clears the last word
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_clr_we    = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we    = 1'b1;
        w_count_nxt = ADDR_WIDTH'(r_count + 1'b1);
        if (r_count == LAST_ADDR) begin
          w_state_nxt = ST_READY;
          w_count_nxt = '0;
        end
      end
      ST_READY: begin
        w_acc_en = 1'b1;
        if (bus.clear) begin
          w_state_nxt = ST_CLEAR;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  // Byte-lane merge; the merged word is both the stored and the returned value
  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      w_wmask[8*i +: 8] = {8{bus.byte_en[i] & bus.write & w_acc_en}};
    end
    w_old_word = r_mem[bus.address];
    w_merged   = (bus.in & w_wmask) | (w_old_word & ~w_wmask);
  end

  // Memory array: sweep writes zero, otherwise masked user write
  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_mem[r_count] <= '0;
    end else if (w_acc_en && bus.write) begin
      r_mem[bus.address] <= w_merged;
    end
  end

  // Read stage 1: capture write-first data on an accepted read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_acc_en & bus.read;
      if (w_acc_en && bus.read) begin
        r_s1_data <= w_merged;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;

      // Read stage 2: extra output register, holds last data when idle
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign bus.out       = r_s2_data;
      assign bus.out_valid = r_s2_valid;
    end else begin : g_no_out_reg
      assign bus.out       = r_s1_data;
      assign bus.out_valid = r_s1_valid;
    end
  endgenerate

  assign bus.ready = (r_state == ST_READY);

endmodule

// File: tb/tb_ram_sp_clear.sv
// Directed bench for ram_sp_clear: latency-1 instance with reset sweep and a
// latency-2 instance without reset sweep.
module tb_ram_sp_clear;

  logic clock;
  logic reset_n;

  int n_checks = 0;
  int n_errors = 0;

  ram_sp_clear_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus1 ();
  ram_sp_clear_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus2 ();

  ram_sp_clear #(
    .DATA_WIDTH(64), .ADDR_WIDTH(8), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u_dut1 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus1.slave)
  );

  ram_sp_clear #(
    .DATA_WIDTH(64), .ADDR_WIDTH(8), .OUT_REG(1), .CLEAR_ON_RESET(0)
  ) u_dut2 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle1();
    bus1.write   = 1'b0;
    bus1.read    = 1'b0;
    bus1.clear   = 1'b0;
    bus1.byte_en = '0;
  endtask

  task automatic idle2();
    bus2.write   = 1'b0;
    bus2.read    = 1'b0;
    bus2.clear   = 1'b0;
    bus2.byte_en = '0;
  endtask

  task automatic read1(input logic [7:0] addr, input logic [63:0] exp, input string tag);
    bus1.address = addr;
    bus1.read    = 1'b1;
    step();
    bus1.read    = 1'b0;
    check({tag, "_valid"}, 64'(bus1.out_valid), 64'd1);
    check({tag, "_data"}, bus1.out, exp);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle1();
    idle2();
    bus1.address = '0;
    bus1.in      = '0;
    bus2.address = '0;
    bus2.in      = '0;
    repeat (3) step();

    check("rst_out",     bus1.out, 64'd0);
    check("rst_valid",   64'(bus1.out_valid), 64'd0);
    check("rst_ready1",  64'(bus1.ready), 64'd0);
    check("rst_ready2",  64'(bus2.ready), 64'd1);
    check("rst_out2",    bus2.out, 64'd0);

    // Reset sweep: ready after exactly 256 cycles
    reset_n = 1'b1;
    repeat (255) step();
    check("sweep_ready_lo", 64'(bus1.ready), 64'd0);
    check("sweep_valid_lo", 64'(bus1.out_valid), 64'd0);
    step();
    check("sweep_ready_hi", 64'(bus1.ready), 64'd1);

    read1(8'h00, 64'd0, "rd0");
    read1(8'h07, 64'd0, "rd7");
    read1(8'hFF, 64'd0, "rd255");

    // Full write then read, then idle
    bus1.address = 8'h10;
    bus1.in      = 64'h0123456789ABCDEF;
    bus1.byte_en = 8'hFF;
    bus1.write   = 1'b1;
    step();
    idle1();
    read1(8'h10, 64'h0123456789ABCDEF, "wr_full");
    step();
    check("idle_valid", 64'(bus1.out_valid), 64'd0);
    check("idle_hold",  bus1.out, 64'h0123456789ABCDEF);

    // Partial write, lower four lanes
    bus1.in      = 64'hFFFF_FFFF_FFFF_FFFF;
    bus1.byte_en = 8'h0F;
    bus1.write   = 1'b1;
    step();
    idle1();
    read1(8'h10, 64'h01234567FFFFFFFF, "wr_part");

    // Write with no lanes enabled changes nothing
    bus1.in      = 64'h0;
    bus1.byte_en = 8'h00;
    bus1.write   = 1'b1;
    step();
    idle1();
    read1(8'h10, 64'h01234567FFFFFFFF, "wr_none");

    // Same-cycle read and write: write-first merge
    bus1.address = 8'h20;
    bus1.in      = 64'hA5A5A5A5A5A5A5A5;
    bus1.byte_en = 8'hF0;
    bus1.write   = 1'b1;
    bus1.read    = 1'b1;
    step();
    idle1();
    check("rw_valid", 64'(bus1.out_valid), 64'd1);
    check("rw_data",  bus1.out, 64'hA5A5A5A5_00000000);
    read1(8'h20, 64'hA5A5A5A5_00000000, "rw_after");

    // Latency-2 instance: fill 1..3 then stream reads
    bus2.byte_en = 8'hFF;
    bus2.write   = 1'b1;
    bus2.address = 8'd1; bus2.in = 64'd11; step();
    bus2.address = 8'd2; bus2.in = 64'd22; step();
    bus2.address = 8'd3; bus2.in = 64'd33; step();
    idle2();
    bus2.read    = 1'b1;
    bus2.address = 8'd1; step();
    check("or_c1_valid", 64'(bus2.out_valid), 64'd0);
    bus2.address = 8'd2; step();
    check("or_c2_valid", 64'(bus2.out_valid), 64'd1);
    check("or_c2_data",  bus2.out, 64'd11);
    bus2.address = 8'd3; step();
    check("or_c3_valid", 64'(bus2.out_valid), 64'd1);
    check("or_c3_data",  bus2.out, 64'd22);
    bus2.read = 1'b0; step();
    check("or_c4_valid", 64'(bus2.out_valid), 64'd1);
    check("or_c4_data",  bus2.out, 64'd33);
    step();
    check("or_c5_valid", 64'(bus2.out_valid), 64'd0);
    check("or_c5_hold",  bus2.out, 64'd33);

    // Clear request with a read in the same cycle: read still delivers
    bus1.address = 8'h10;
    bus1.read    = 1'b1;
    bus1.clear   = 1'b1;
    step();
    idle1();
    check("clr_rd_valid", 64'(bus1.out_valid), 64'd1);
    check("clr_rd_data",  bus1.out, 64'h01234567FFFFFFFF);
    check("clr_ready",    64'(bus1.ready), 64'd0);
    for (int i = 0; i < 255; i++) begin
      if (i == 100) begin
        bus1.clear   = 1'b1;
        bus1.read    = 1'b1;
        bus1.write   = 1'b1;
        bus1.byte_en = 8'hFF;
        bus1.in      = 64'h1111_2222_3333_4444;
        bus1.address = 8'h10;
      end
      step();
      if (i == 100) begin
        idle1();
        check("sweep_rd_ignored", 64'(bus1.out_valid), 64'd0);
      end
    end
    check("clr_ready_lo", 64'(bus1.ready), 64'd0);
    step();
    check("clr_ready_hi", 64'(bus1.ready), 64'd1);
    read1(8'h10, 64'd0, "clr_rd10");
    read1(8'h20, 64'd0, "clr_rd20");

    // Clear with write+read in the same cycle, then reset mid-sweep
    bus1.address = 8'h30;
    bus1.in      = 64'hDEADBEEF_CAFEF00D;
    bus1.byte_en = 8'hFF;
    bus1.write   = 1'b1;
    bus1.read    = 1'b1;
    bus1.clear   = 1'b1;
    step();
    idle1();
    check("clr2_data", bus1.out, 64'hDEADBEEF_CAFEF00D);
    repeat (100) step();
    check("clr2_hold", bus1.out, 64'hDEADBEEF_CAFEF00D);
    check("clr2_ready", 64'(bus1.ready), 64'd0);
    reset_n = 1'b0;
    #2;
    check("midrst_out",   bus1.out, 64'd0);
    check("midrst_valid", 64'(bus1.out_valid), 64'd0);
    step();
    reset_n = 1'b1;
    repeat (255) step();
    check("rerun_ready_lo", 64'(bus1.ready), 64'd0);
    step();
    check("rerun_ready_hi", 64'(bus1.ready), 64'd1);
    read1(8'h30, 64'd0, "rerun_rd30");
    read1(8'hFF, 64'd0, "rerun_rd255");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
